// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: controller states, register-number width
// and the instruction word loaded into IF/ID on a flush.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   localparam int REG_W = 5;

   // sll $0,$0,0 -- the canonical MIPS NOP
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/md_busy_timer.sv
// Occupancy timer for the multiply/divide unit: loads MD_LAT-1 on start,
// counts down while waiting and unfrozen, and reports zero/busy.
module md_busy_timer #(
   parameter int MD_LAT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic in_wait,
   input  logic freeze,
   output logic cnt_zero,
   output logic md_busy
);

   localparam logic [5:0] LOAD_VAL = 6'(MD_LAT - 1);

   logic [5:0] md_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         md_cnt <= 6'd0;
      end else if (!freeze) begin
         if (load)
            md_cnt <= LOAD_VAL;
         else if (in_wait && (md_cnt != 6'd0))
            md_cnt <= md_cnt - 6'd1;
      end
   end

   assign cnt_zero = (md_cnt == 6'd0);
   assign md_busy  = in_wait && !cnt_zero;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Define HAZARD_CTRL_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             id_md_dep,
   input  logic             id_jump,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_md_start,
   input  logic             dmem_ready,
   output logic             pc_wr_en,
   output logic             if_id_wr_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_freeze,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   state_t state_q, state_d;
   logic   freeze;
   logic   lu;
   logic   mdh;
   logic   cnt_zero;
   logic   stall_act;

   assign freeze = !dmem_ready;

   assign lu = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   assign mdh = (state_q == MD_WAIT) && id_md_dep && !cnt_zero;

   md_busy_timer #(
      .MD_LAT (MD_LAT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     ((state_q == RUN) && ex_md_start),
      .in_wait  (state_q == MD_WAIT),
      .freeze   (freeze),
      .cnt_zero (cnt_zero),
      .md_busy  (md_busy)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!freeze) begin
         case (state_q)
            RUN:     if (ex_md_start) state_d = MD_WAIT;
            MD_WAIT: if (cnt_zero)    state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   assign stall_act = !freeze && !ex_branch_taken && (lu || mdh);

   // Priority: freeze > branch > stall > jump > run. Reset forces a held, bubbled pipe.
   always_comb begin
      pc_wr_en     = 1'b1;
      if_id_wr_en  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      if (!rst) begin
         pc_wr_en     = 1'b0;
         if_id_wr_en  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (freeze) begin
         pc_wr_en     = 1'b0;
         if_id_wr_en  = 1'b0;
         pipe_freeze  = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_wr_en  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (lu || mdh) begin
         pc_wr_en     = 1'b0;
         if_id_wr_en  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (id_jump) begin
         if_id_wr_en  = 1'b0;
         if_id_flush  = 1'b1;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if ((freeze || stall_act) && !(&stall_q))
            stall_q <= stall_q + 1'b1;
         if (if_id_flush && !(&flush_q))
            flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   logic unused_perf;
   assign unused_perf  = stall_act;
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MD_LAT=4, narrow counters to reach saturation).
`timescale 1ns/1ps
module tb_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int CNT_W  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
   logic             id_uses_rt = 1'b0, id_md_dep = 1'b0, id_jump = 1'b0;
   logic             ex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_md_start = 1'b0;
   logic             dmem_ready = 1'b1;
   logic             pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, pipe_freeze, md_busy;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_md_dep(id_md_dep),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start), .dmem_ready(dmem_ready),
      .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .md_busy(md_busy),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   // {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, pipe_freeze, md_busy}
   localparam logic [5:0] O_RUN  = 6'b110000;
   localparam logic [5:0] O_STL  = 6'b000100;
   localparam logic [5:0] O_STLB = 6'b000101;
   localparam logic [5:0] O_BR   = 6'b101100;
   localparam logic [5:0] O_JMP  = 6'b101000;
   localparam logic [5:0] O_FRZ  = 6'b000010;
   localparam logic [5:0] O_FRZB = 6'b000011;
   localparam logic [5:0] O_RST  = 6'b000100;

   typedef struct {
      logic [5:0]       o;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
      string            nm;
   } exp_t;

   exp_t             sb[$];
   int               n_cmp  = 0;
   int               n_fail = 0;
   logic [CNT_W-1:0] m_sc   = '0;
   logic [CNT_W-1:0] m_fc   = '0;

   task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic dep, input logic jmp,
                      input logic mrd, input logic [4:0] xrt, input logic br,
                      input logic mds, input logic rdy, input logic [5:0] exp_o,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_md_dep = dep;
      id_jump = jmp; ex_mem_read = mrd; ex_rt = xrt; ex_branch_taken = br;
      ex_md_start = mds; dmem_ready = rdy;
      if (!r) begin
         m_sc = '0;
         m_fc = '0;
      end
      e.o  = exp_o;
      e.nm = nm;
`ifdef HAZARD_CTRL_PERF_EN
      e.sc = m_sc;
      e.fc = m_fc;
`else
      e.sc = '0;
      e.fc = '0;
`endif
      sb.push_back(e);
      if (r) begin
         if ((exp_o[1] || (exp_o[2] && !exp_o[3])) && !(&m_sc)) m_sc = m_sc + 1'b1;
         if (exp_o[3] && !(&m_fc)) m_fc = m_fc + 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e   = sb.pop_front();
         act = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, pipe_freeze, md_busy};
         n_cmp++;
         if (act !== e.o || stall_cycles !== e.sc || flush_events !== e.fc) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                     e.nm, act, stall_cycles, flush_events, e.o, e.sc, e.fc);
         end
      end
   end

   initial begin
      repeat (2000) @(posedge clk);
      $display("FAIL watchdog: got no end of stimulus, want finish within 2000 cycles");
      $fatal(1, "timeout");
   end

   initial begin
      //  rst rs  rt  urt dep jmp mrd xrt br  mds rdy  expect
      cyc(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  O_RST,  "reset_hold");
      cyc(1, 0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  O_RUN,  "first_run");
      cyc(1, 8,  0,  0,  0,  0,  1,  8,  0,  0,  1,  O_STL,  "lu_rs");
      cyc(1, 8,  0,  0,  0,  0,  0,  0,  0,  0,  1,  O_RUN,  "lu_one_cycle");
      cyc(1, 1,  9,  1,  0,  0,  1,  9,  0,  0,  1,  O_STL,  "lu_rt");
      cyc(1, 1,  9,  0,  0,  0,  1,  9,  0,  0,  1,  O_RUN,  "lu_rt_unused");
      cyc(1, 0,  0,  0,  0,  0,  1,  0,  0,  0,  1,  O_RUN,  "lu_r0");
      cyc(1, 8,  0,  0,  0,  1,  1,  8,  1,  0,  1,  O_BR,   "branch_over_lu_jump");
      cyc(1, 8,  0,  0,  0,  1,  1,  8,  0,  0,  1,  O_STL,  "jump_lu_stall");
      cyc(1, 8,  0,  0,  0,  1,  0,  0,  0,  0,  1,  O_JMP,  "jump_flush");
      // MD wait: start, then three dependent stalls, then issue
      cyc(1, 0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  O_RUN,  "md_start");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md_stall1");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md_stall2");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md_stall3");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_RUN,  "md_issue");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_RUN,  "md_dep_in_run");
      // MD wait with two freeze cycles: five dependent stall cycles
      cyc(1, 0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  O_RUN,  "md2_start");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md2_stall1");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  O_FRZB, "md2_freeze1");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  0,  O_FRZB, "md2_freeze2");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md2_stall2");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md2_stall3");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_RUN,  "md2_issue");
      cyc(1, 8,  0,  0,  0,  1,  1,  8,  1,  0,  0,  O_FRZ,  "freeze_over_branch");
      // Asynchronous reset in the middle of an MD wait
      cyc(1, 0,  0,  0,  0,  0,  0,  0,  0,  1,  1,  O_RUN,  "md3_start");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_STLB, "md3_stall1");
      cyc(0, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_RST,  "async_rst_mid_wait");
      cyc(1, 0,  0,  0,  1,  0,  0,  0,  0,  0,  1,  O_RUN,  "post_rst_run");
      cyc(1, 0,  0,  0,  0,  1,  0,  0,  0,  0,  1,  O_JMP,  "post_rst_jump");
      cyc(1, 0,  0,  0,  0,  0,  0,  0,  1,  0,  1,  O_BR,   "post_rst_branch");
      cyc(1, 0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  O_RUN,  "final_idle");
      @(posedge clk);
      @(posedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
